// File: rtl/lock_code_entry.sv
// lock_code_entry: keypad lock with synchronised key events, attempt limiting and timed lockout.
// Optional inter-digit timeout is compiled in when LOCK_TIMEOUT_EN is defined.

module lock_key_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic s1_q, s1_d, s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;
endmodule

module lock_code_entry #(
  parameter int                  NUM_KEYS       = 9,
  parameter int                  DIGITS         = 4,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  LOCKOUT_CYCLES = 1000,
  parameter logic [4*DIGITS-1:0] RESET_CODE     = 16'h1234,
  parameter int                  TIMEOUT_CYCLES = 5000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_KEYS-1:0]           keys,
  input  logic                          clear,
  input  logic                          lock,
  input  logic                          set_code,
  output logic [3:0]                    digit,
  output logic                          digit_valid,
  output logic [$clog2(DIGITS+1)-1:0]   entry_count,
  output logic                          unlocked,
  output logic                          prog_mode,
  output logic                          lockout,
  output logic                          err
);
  localparam int CW = $clog2(DIGITS+1);
  localparam int FW = $clog2(MAX_TRIES+1);
  localparam int LW = $clog2(LOCKOUT_CYCLES+1);
  localparam int BW = 4*DIGITS;

  typedef enum logic [2:0] {
    LOCKED  = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    PROGRAM = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d, code_q, code_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lo_q, lo_d;
  logic [3:0]    digit_q, digit_d, enc;
  logic          dv_q, dv_d, err_q, err_d;
  logic          anykey_q, anykey_d;
  logic [NUM_KEYS-1:0] key_s;
  logic          press, capture, last, timeout;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_sync
    lock_key_sync u_sync (.clk(clk), .rst_n(rst_n), .d(keys[i]), .q(key_s[i]));
  end

  // Highest-index key wins; later iterations overwrite earlier ones.
  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (key_s[i]) enc = 4'(i + 1);
  end

  assign anykey_d = |key_s;
  assign press    = anykey_d & ~anykey_q;
  assign capture  = press & ((state_q == LOCKED) | (state_q == PROGRAM));
  assign last     = (cnt_q == CW'(DIGITS - 1));

`ifdef LOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] to_q, to_d;
  logic          to_run;

  // Idle time since the last capture; any capture or clear restarts it.
  always_comb begin
    to_run  = ((state_q == LOCKED) | (state_q == PROGRAM)) & (cnt_q != '0) & ~capture & ~clear;
    timeout = to_run & (to_q == TW'(TIMEOUT_CYCLES - 1));
    to_d    = (to_run & ~timeout) ? to_q + TW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= '0;
    else        to_q <= to_d;
  end
`else
  logic unused_to;
  assign timeout   = 1'b0;
  assign unused_to = (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    fail_d  = fail_q;
    lo_d    = lo_q;
    digit_d = digit_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    shifted = buf_q << 4;
    shifted[3:0] = enc;

    if (capture) begin
      digit_d = enc;
      dv_d    = 1'b1;
    end

    case (state_q)
      LOCKED: begin
        if (clear) begin
          cnt_d = '0;
          buf_d = '0;
        end else if (capture) begin
          buf_d = shifted;
          cnt_d = cnt_q + CW'(1);
          if (last) state_d = CHECK;
        end else if (timeout) begin
          cnt_d = '0;
          buf_d = '0;
          err_d = 1'b1;
        end
      end
      CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if (buf_q == code_q) begin
          fail_d  = '0;
          state_d = OPEN;
        end else if (int'(fail_q) + 1 >= MAX_TRIES) begin
          err_d   = 1'b1;
          fail_d  = '0;
          lo_d    = LW'(LOCKOUT_CYCLES);
          state_d = LOCKOUT;
        end else begin
          err_d   = 1'b1;
          fail_d  = fail_q + FW'(1);
          state_d = LOCKED;
        end
      end
      OPEN: begin
        if (lock)          state_d = LOCKED;
        else if (set_code) state_d = PROGRAM;
      end
      PROGRAM: begin
        if (clear) begin
          cnt_d   = '0;
          buf_d   = '0;
          state_d = OPEN;
        end else if (capture) begin
          if (last) begin
            code_d  = shifted;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = OPEN;
          end else begin
            buf_d = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end else if (timeout) begin
          cnt_d   = '0;
          buf_d   = '0;
          err_d   = 1'b1;
          state_d = OPEN;
        end
      end
      LOCKOUT: begin
        // Leave as the counter hits zero so lockout lasts exactly LOCKOUT_CYCLES.
        if (lo_q <= LW'(1)) begin
          lo_d    = '0;
          state_d = LOCKED;
        end else begin
          lo_d = lo_q - LW'(1);
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOCKED;
      buf_q    <= '0;
      code_q   <= RESET_CODE;
      cnt_q    <= '0;
      fail_q   <= '0;
      lo_q     <= '0;
      digit_q  <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      anykey_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      lo_q     <= lo_d;
      digit_q  <= digit_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      anykey_q <= anykey_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = dv_q;
  assign entry_count = cnt_q;
  assign unlocked    = (state_q == OPEN) | (state_q == PROGRAM);
  assign prog_mode   = (state_q == PROGRAM);
  assign lockout     = (state_q == LOCKOUT);
  assign err         = err_q;
endmodule

// File: tb/tb_lock_code_entry.sv
// Scoreboard bench for lock_code_entry: stimulus queues expected digits/err pulses, a monitor pops them.
module tb_lock_code_entry;
  localparam int NK = 9;
  localparam int DG = 4;
  localparam int CW = $clog2(DG+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] keys = '0;
  logic          clear = 1'b0, lock = 1'b0, set_code = 1'b0;
  logic [3:0]    digit;
  logic          digit_valid;
  logic [CW-1:0] entry_count;
  logic          unlocked, prog_mode, lockout, err;

  int         checks = 0, errors = 0, lo_cycles = 0;
  logic [3:0] exp_dig[$];
  int         exp_err[$];

  always #5 clk = ~clk;

  lock_code_entry #(.NUM_KEYS(NK), .DIGITS(DG), .MAX_TRIES(3), .LOCKOUT_CYCLES(1000),
                    .RESET_CODE(16'h1234), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .clear(clear), .lock(lock), .set_code(set_code),
    .digit(digit), .digit_valid(digit_valid), .entry_count(entry_count), .unlocked(unlocked),
    .prog_mode(prog_mode), .lockout(lockout), .err(err));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every digit_valid / err pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lockout) lo_cycles++;
      if (digit_valid) begin
        if (exp_dig.size() == 0) check("digit_valid unexpected, digit", int'(digit), 0);
        else check("captured digit", int'(digit), int'(exp_dig.pop_front()));
      end
      if (err) begin
        check("err pulse expected", exp_err.size(), 1);
        if (exp_err.size() > 0) void'(exp_err.pop_front());
      end
    end
  end

  task automatic press(input int k, input bit cap, input bit clr_cap = 1'b0);
    if (cap) exp_dig.push_back(4'(k + 1));
    @(posedge clk); #1 keys = '0; keys[k] = 1'b1;
    if (clr_cap) begin
      // clear lands on the cycle the press event is captured
      repeat (2) @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      repeat (2) @(posedge clk);
    end else begin
      repeat (5) @(posedge clk);
    end
    #1 keys = '0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    press(a - 1, 1'b1);
    press(b - 1, 1'b1);
    press(c - 1, 1'b1);
    press(d - 1, 1'b1);
  endtask

  // 0 clear, 1 lock, 2 set_code, 3 lock+set_code
  task automatic pulse(input int which);
    @(posedge clk); #1;
    clear    = (which == 0);
    lock     = (which == 1) || (which == 3);
    set_code = (which == 2) || (which == 3);
    @(posedge clk); #1 clear = 1'b0; lock = 1'b0; set_code = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drained(input string name);
    check({name, " err queue"}, exp_err.size(), 0);
    check({name, " digit queue"}, exp_dig.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    check("reset digit", digit, 0);
    check("reset digit_valid", digit_valid, 0);
    check("reset entry_count", entry_count, 0);
    check("reset unlocked", unlocked, 0);
    check("reset lockout", lockout, 0);
    check("reset err", err, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Correct reset code
    enter4(1, 2, 3, 4);
    check("unlock 1234", unlocked, 1);
    check("prog_mode in OPEN", prog_mode, 0);
    press(4, 1'b0);
    check("OPEN ignores keys, count", entry_count, 0);
    pulse(1);
    check("relocked", unlocked, 0);

    // Multiple keys: highest index wins, changes while held ignored
    exp_dig.push_back(4'd9);
    @(posedge clk); #1 keys = 9'b100000100;
    repeat (4) @(posedge clk); #1 keys = 9'b000000101;
    repeat (4) @(posedge clk); #1 keys = 9'b010000001;
    repeat (4) @(posedge clk); #1 keys = '0;
    repeat (4) @(posedge clk); #1;
    check("multi-key single event count", entry_count, 1);
    check("multi-key digit held", digit, 9);
    pulse(0);
    check("clear in LOCKED", entry_count, 0);
    drained("multi-key");

    // Three failed attempts -> lockout
    exp_err.push_back(1);
    enter4(1, 1, 1, 1);
    drained("fail 1");
    check("fail 1 lockout", lockout, 0);
    exp_err.push_back(2);
    enter4(1, 1, 1, 1);
    drained("fail 2");
    check("fail 2 lockout", lockout, 0);
    exp_err.push_back(3);
    lo_cycles = 0;
    enter4(1, 1, 1, 1);
    drained("fail 3");
    check("lockout asserted", lockout, 1);
    check("lockout entry_count", entry_count, 0);
    press(2, 1'b0);
    for (int i = 0; i < 3000 && lockout; i++) @(negedge clk);
    check("lockout released", lockout, 0);
    check("lockout duration", lo_cycles, 1000);
    @(posedge clk); #1;
    check("after lockout unlocked", unlocked, 0);
    enter4(1, 2, 3, 4);
    check("unlock after lockout", unlocked, 1);

    // Program new code 5678
    pulse(2);
    check("program mode", prog_mode, 1);
    check("program unlocked", unlocked, 1);
    enter4(5, 6, 7, 8);
    check("program done prog_mode", prog_mode, 0);
    check("program done unlocked", unlocked, 1);
    pulse(1);
    exp_err.push_back(4);
    enter4(1, 2, 3, 4);
    drained("old code");
    check("old code rejected", unlocked, 0);
    enter4(5, 6, 7, 8);
    check("new code accepted", unlocked, 1);
    pulse(1);

    // clear mid-entry, then clear on the final capture
    press(4, 1'b1);
    press(5, 1'b1);
    check("partial count", entry_count, 2);
    pulse(0);
    check("cleared partial", entry_count, 0);
    enter4(5, 6, 7, 8);
    check("unlock after clear", unlocked, 1);
    pulse(1);
    press(4, 1'b1);
    press(5, 1'b1);
    press(6, 1'b1);
    press(7, 1'b1, 1'b1);
    check("clear wins count", entry_count, 0);
    check("clear wins no unlock", unlocked, 0);
    drained("clear on final");
    enter4(5, 6, 7, 8);
    check("unlock after final clear", unlocked, 1);

    // Abandon programming, code unchanged
    pulse(2);
    press(0, 1'b1);
    pulse(0);
    check("abandon prog_mode", prog_mode, 0);
    check("abandon unlocked", unlocked, 1);
    check("abandon count", entry_count, 0);
    pulse(1);
    enter4(5, 6, 7, 8);
    check("code kept after abandon", unlocked, 1);

    // lock beats set_code
    pulse(3);
    check("lock wins unlocked", unlocked, 0);
    check("lock wins prog_mode", prog_mode, 0);

    // Reset mid-program restores RESET_CODE
    enter4(5, 6, 7, 8);
    pulse(2);
    press(8, 1'b1);
    press(8, 1'b1);
    check("program partial", entry_count, 2);
    rst_n = 1'b0;
    #1;
    check("async reset unlocked", unlocked, 0);
    check("async reset prog_mode", prog_mode, 0);
    check("async reset count", entry_count, 0);
    check("async reset digit", digit, 0);
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    enter4(1, 2, 3, 4);
    check("reset code restored", unlocked, 1);
    pulse(1);

`ifdef LOCK_TIMEOUT_EN
    exp_err.push_back(10);
    enter4(1, 1, 1, 1);
    exp_err.push_back(11);
    press(0, 1'b1);
    repeat (60) @(posedge clk); #1;
    check("timeout count", entry_count, 0);
    drained("timeout 1");
    exp_err.push_back(12);
    press(1, 1'b1);
    repeat (60) @(posedge clk); #1;
    drained("timeout 2");
    exp_err.push_back(13);
    enter4(1, 1, 1, 1);
    drained("fail after timeouts");
    check("timeouts do not count as fails", lockout, 0);
    enter4(1, 2, 3, 4);
    check("unlock after timeouts", unlocked, 1);
`else
    press(0, 1'b1);
    repeat (60) @(posedge clk); #1;
    check("partial persists", entry_count, 1);
    pulse(0);
    check("partial cleared", entry_count, 0);
`endif

    repeat (5) @(posedge clk); #1;
    drained("end");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
